// File: rtl/inst_loader_if.sv
// Byte-stream input and instruction-memory write port of the boot loader.
// The loader side is the slave; the feeder/memory side is the master.
interface inst_loader_if;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;

  modport slave  (input in_valid, in_data, output in_ready, mem_we, mem_addr, mem_wdata);
  modport master (output in_valid, in_data, input in_ready, mem_we, mem_addr, mem_wdata);
endinterface

// File: rtl/inst_loader.sv
// Boot-time instruction-memory loader: length, big-endian words, XOR checksum.
// Holds the CPU in reset until a complete, checksum-verified image is written.
module inst_loader #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int unsigned MAX_WORDS = 32'd256
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  inst_loader_if.slave bus,
  output logic         busy,
  output logic         done,
  output logic         error,
  output logic         cpu_hold
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LEN_HI = 3'd1,
    S_LEN_LO = 3'd2,
    S_DATA   = 3'd3,
    S_CHK    = 3'd4,
    S_DONE   = 3'd5,
    S_ERR    = 3'd6
  } state_t;

  state_t      state_r;
  state_t      next_state_s;
  logic [15:0] count_r;
  logic [15:0] index_r;
  logic [1:0]  byte_cnt_r;
  logic [23:0] shift_r;
  logic [7:0]  chk_acc_r;
  logic        mem_we_r;
  logic [31:0] mem_addr_r;
  logic [31:0] mem_wdata_r;
  logic        in_ready_r;
  logic        busy_r;
  logic        done_r;
  logic        error_r;
  logic        cpu_hold_r;

  logic        in_ready_s;
  logic        busy_s;
  logic        done_s;
  logic        error_s;
  logic        cpu_hold_s;
  logic        accept_s;
  logic [15:0] len_s;
  logic        last_word_s;

  function automatic logic [7:0] chk_update(input logic [7:0] acc, input logic [7:0] b);
    return acc ^ b;
  endfunction

  assign accept_s    = bus.in_valid && in_ready_r;
  assign len_s       = {count_r[15:8], bus.in_data};
  assign last_word_s = (index_r == (count_r - 16'd1)) && (byte_cnt_r == 2'd3);

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state decode
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      S_IDLE, S_DONE, S_ERR: begin
        if (start) next_state_s = S_LEN_HI;
        else       next_state_s = state_r;
      end
      S_LEN_HI: begin
        if (accept_s) next_state_s = S_LEN_LO;
        else          next_state_s = state_r;
      end
      S_LEN_LO: begin
        if (accept_s) begin
          if ((len_s == 16'd0) || (32'(len_s) > MAX_WORDS)) next_state_s = S_ERR;
          else                                              next_state_s = S_DATA;
        end else begin
          next_state_s = state_r;
        end
      end
      S_DATA: begin
        if (accept_s && last_word_s) next_state_s = S_CHK;
        else                         next_state_s = state_r;
      end
      S_CHK: begin
        if (accept_s) begin
          if (bus.in_data == chk_acc_r) next_state_s = S_DONE;
          else                          next_state_s = S_ERR;
        end else begin
          next_state_s = state_r;
        end
      end
      default: next_state_s = S_IDLE;
    endcase
  end

  // Status decode from the upcoming state so the registered copies line up with it
  always_comb begin
    in_ready_s = 1'b0;
    busy_s     = 1'b0;
    done_s     = 1'b0;
    error_s    = 1'b0;
    cpu_hold_s = 1'b1;
    case (next_state_s)
      S_LEN_HI, S_LEN_LO, S_DATA, S_CHK: begin
        in_ready_s = 1'b1;
        busy_s     = 1'b1;
      end
      S_DONE:  begin
        done_s     = 1'b1;
        cpu_hold_s = 1'b0;
      end
      S_ERR:   error_s = 1'b1;
      S_IDLE:  cpu_hold_s = 1'b1;
      default: cpu_hold_s = 1'b1;
    endcase
  end

  // Registered status outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      in_ready_r <= 1'b0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      error_r    <= 1'b0;
      cpu_hold_r <= 1'b1;
    end else begin
      in_ready_r <= in_ready_s;
      busy_r     <= busy_s;
      done_r     <= done_s;
      error_r    <= error_s;
      cpu_hold_r <= cpu_hold_s;
    end
  end

  // Length capture, word assembly, checksum and memory write strobe
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_r     <= 16'd0;
      index_r     <= 16'd0;
      byte_cnt_r  <= 2'd0;
      shift_r     <= 24'd0;
      chk_acc_r   <= 8'd0;
      mem_we_r    <= 1'b0;
      mem_addr_r  <= BASE_ADDR;
      mem_wdata_r <= 32'd0;
    end else begin
      mem_we_r <= 1'b0;
      case (state_r)
        S_IDLE, S_DONE, S_ERR: begin
          if (start) begin
            index_r    <= 16'd0;
            byte_cnt_r <= 2'd0;
            chk_acc_r  <= 8'd0;
          end
        end
        S_LEN_HI: if (accept_s) count_r[15:8] <= bus.in_data;
        S_LEN_LO: if (accept_s) count_r[7:0]  <= bus.in_data;
        S_DATA: begin
          if (accept_s) begin
            shift_r    <= {shift_r[15:0], bus.in_data};
            chk_acc_r  <= chk_update(chk_acc_r, bus.in_data);
            byte_cnt_r <= byte_cnt_r + 2'd1;
            if (byte_cnt_r == 2'd3) begin
              // Word-aligned byte address, stepping like PC+4; wraps mod 2^32
              mem_we_r    <= 1'b1;
              mem_addr_r  <= BASE_ADDR + {14'd0, index_r, 2'b00};
              mem_wdata_r <= {shift_r, bus.in_data};
              index_r     <= index_r + 16'd1;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_r;
  assign bus.mem_we    = mem_we_r;
  assign bus.mem_addr  = mem_addr_r;
  assign bus.mem_wdata = mem_wdata_r;
  assign busy          = busy_r;
  assign done          = done_r;
  assign error         = error_r;
  assign cpu_hold      = cpu_hold_r;

endmodule

// File: tb/tb_inst_loader.sv
// Self-checking bench for inst_loader: directed and randomized image loads
// compared against a stream-level reference model.
module tb_inst_loader;
  localparam logic [31:0] BASE = 32'h0000_0000;
  localparam int unsigned MAXW = 256;

  typedef logic [7:0] bq_t[$];

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic start = 1'b0;
  logic busy, done, error, cpu_hold;

  inst_loader_if dif();

  inst_loader #(.BASE_ADDR(BASE), .MAX_WORDS(MAXW)) dut (
    .clk(clk), .rst(rst), .start(start), .bus(dif),
    .busy(busy), .done(done), .error(error), .cpu_hold(cpu_hold)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  logic [31:0] obs_addr[$];
  logic [31:0] obs_data[$];
  logic [31:0] exp_addr[$];
  logic [31:0] exp_data[$];
  logic exp_done, exp_error;

  // Write monitor, sampled away from the active edge
  always @(negedge clk) begin
    if (dif.mem_we === 1'b1) begin
      obs_addr.push_back(dif.mem_addr);
      obs_data.push_back(dif.mem_wdata);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chkb(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Reference: parse the byte stream into the writes and verdict it must produce
  task automatic model(input bq_t s);
    int unsigned n;
    logic [7:0]  x;
    logic [31:0] w;
    exp_addr.delete();
    exp_data.delete();
    exp_done  = 1'b0;
    exp_error = 1'b0;
    n = {16'd0, s[0], s[1]};
    if (n == 0 || n > MAXW) begin
      exp_error = 1'b1;
    end else begin
      x = 8'h00;
      for (int i = 0; i < int'(n); i++) begin
        w = {s[2+4*i], s[3+4*i], s[4+4*i], s[5+4*i]};
        x = x ^ w[31:24] ^ w[23:16] ^ w[15:8] ^ w[7:0];
        exp_addr.push_back(BASE + 32'(4 * i));
        exp_data.push_back(w);
      end
      if (s[2+4*n] == x) exp_done = 1'b1;
      else               exp_error = 1'b1;
    end
  endtask

  // Offer one byte (optionally after an in_valid gap); returns at the negedge after acceptance
  task automatic send_byte(input logic [7:0] b, input int gap_pct);
    int guard;
    if ($urandom_range(0, 99) < gap_pct) begin
      dif.in_valid = 1'b0;
      repeat ($urandom_range(1, 4)) @(negedge clk);
    end
    dif.in_valid = 1'b1;
    dif.in_data  = b;
    guard = 0;
    while (dif.in_ready !== 1'b1 && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    chkb("accept_timeout", guard >= 50, 1'b0);
    @(negedge clk);
  endtask

  task automatic run_load(input bq_t s, input int gap_pct, input string tag);
    model(s);
    obs_addr.delete();
    obs_data.delete();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chkb({tag, "_busy_start"}, busy, 1'b1);
    chkb({tag, "_hold_start"}, cpu_hold, 1'b1);
    chkb({tag, "_done_clr"}, done, 1'b0);
    foreach (s[i]) send_byte(s[i], gap_pct);
    dif.in_valid = 1'b0;
    chkb({tag, "_done"}, done, exp_done);
    chkb({tag, "_error"}, error, exp_error);
    chkb({tag, "_hold_end"}, cpu_hold, ~exp_done);
    chkb({tag, "_busy_end"}, busy, 1'b0);
    repeat (2) @(negedge clk);
    chk({tag, "_nwrites"}, 32'(obs_addr.size()), 32'(exp_addr.size()));
    if (obs_addr.size() == exp_addr.size()) begin
      foreach (exp_addr[i]) begin
        chk($sformatf("%s_addr%0d", tag, i), obs_addr[i], exp_addr[i]);
        chk($sformatf("%s_data%0d", tag, i), obs_data[i], exp_data[i]);
      end
    end
  endtask

  initial begin
    bq_t q;
    int unsigned n;
    logic [7:0] x;
    logic [7:0] b;
    dif.in_valid = 1'b0;
    dif.in_data  = 8'h00;

    #12;
    chkb("rst_in_ready", dif.in_ready, 1'b0);
    chkb("rst_mem_we", dif.mem_we, 1'b0);
    chk("rst_mem_addr", dif.mem_addr, BASE);
    chk("rst_mem_wdata", dif.mem_wdata, 32'h0);
    chkb("rst_busy", busy, 1'b0);
    chkb("rst_done", done, 1'b0);
    chkb("rst_error", error, 1'b0);
    chkb("rst_cpu_hold", cpu_hold, 1'b1);
    @(negedge clk);
    rst = 1'b1;

    // Reset mid-stream: one word written, the partial second word is dropped
    obs_addr.delete();
    obs_data.delete();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    q = '{8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05, 8'h20};
    foreach (q[i]) send_byte(q[i], 0);
    dif.in_valid = 1'b0;
    chk("mid_wdata_before", dif.mem_wdata, 32'h2008_0005);
    #2 rst = 1'b0;
    #1;
    chk("mid_rst_wdata", dif.mem_wdata, 32'h0);
    chk("mid_rst_addr", dif.mem_addr, BASE);
    chkb("mid_rst_busy", busy, 1'b0);
    chkb("mid_rst_in_ready", dif.in_ready, 1'b0);
    chkb("mid_rst_cpu_hold", cpu_hold, 1'b1);
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("mid_rst_nwrites", 32'(obs_addr.size()), 32'd1);

    // Bytes offered in IDLE are not consumed
    dif.in_valid = 1'b1;
    dif.in_data  = 8'h55;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chkb("idle_in_ready", dif.in_ready, 1'b0);
    end
    dif.in_valid = 1'b0;

    q = '{8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05, 8'h20, 8'h09, 8'h00, 8'h0A, 8'h0E};
    run_load(q, 0, "nominal");
    chkb("nominal_done_const", done, 1'b1);
    q[10] = 8'h0F;
    run_load(q, 0, "badchk");
    run_load('{8'h00, 8'h00}, 0, "len0");
    run_load('{8'h01, 8'h01}, 0, "len257");
    q[10] = 8'h0E;
    run_load(q, 40, "gaps");
    run_load('{8'h00, 8'h01, 8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h00}, 0, "restart");
    chk("restart_wdata", dif.mem_wdata, 32'hAABB_CCDD);

    // Randomized images: good, corrupted checksum and out-of-range length
    for (int t = 0; t < 10; t++) begin
      q.delete();
      case ($urandom_range(0, 3))
        0: begin
          n = $urandom_range(257, 65535);
          q.push_back(n[15:8]);
          q.push_back(n[7:0]);
        end
        default: begin
          n = $urandom_range(1, 8);
          q.push_back(n[15:8]);
          q.push_back(n[7:0]);
          x = 8'h00;
          for (int i = 0; i < int'(4 * n); i++) begin
            b = 8'($urandom);
            x = x ^ b;
            q.push_back(b);
          end
          if ($urandom_range(0, 3) == 0) x = x ^ 8'($urandom_range(1, 255));
          q.push_back(x);
        end
      endcase
      run_load(q, 30, $sformatf("rand%0d", t));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/inst_loader.md
# inst_loader

Boot-time writer for the instruction memory: receives a byte stream (word count, big-endian instruction words, XOR checksum) over a valid/ready handshake. It writes each assembled 32-bit word into instruction memory at word-aligned byte addresses, stepping by 4 to match the program counter's PC+4 sequencing. It holds the CPU (program counter) in reset until the image is fully and correctly loaded.

## Interface
Parameters:
- BASE_ADDR, 32'h00000000, byte address of the first instruction written
- MAX_WORDS, 256, largest accepted word count (1..65535)

Ports:
- clk  input  1  single clock; all state updates on rising edge
- rst  input  1  asynchronous, active-low reset
- start  input  1  one-cycle request to begin a load
- in_valid  input  1  in_data holds a valid byte
- in_data  input  8  stream byte
- in_ready  output  1  loader accepts a byte this cycle
- mem_we  output  1  one-cycle write strobe to instruction memory
- mem_addr  output  32  byte address of the write
- mem_wdata  output  32  instruction word to write
- busy  output  1  load in progress
- done  output  1  image loaded and checksum matched
- error  output  1  bad length or checksum mismatch
- cpu_hold  output  1  drives the CPU/program-counter reset; 1 = hold

## Operation
- FSM states: IDLE, LEN_HI, LEN_LO, DATA, CHK, DONE, ERR.
- A byte is accepted on a rising edge with in_valid && in_ready. in_ready is Moore: 1 in LEN_HI, LEN_LO, DATA, CHK; 0 otherwise. Bytes offered while in_ready = 0 are not consumed.
- IDLE/DONE/ERR + start -> LEN_HI. This clears the word index, byte counter and checksum accumulator, deasserts done/error and asserts cpu_hold. start in any other state is ignored.
- LEN_HI: accept byte as count[15:8] -> LEN_LO.
- LEN_LO: accept byte as count[7:0]. If count == 0 or count > MAX_WORDS -> ERR; else -> DATA.
- DATA: accept bytes MSB first into a 32-bit shift register and XOR each byte into chk_acc.
  - On the 4th byte of a word: mem_we = 1, mem_addr = BASE_ADDR + 4*index, mem_wdata = assembled word, all registered and visible the next cycle; index increments.
  - After the word with index count-1 -> CHK.
- CHK: accept one byte. If it equals chk_acc -> DONE; else -> ERR. Checksum covers data bytes only, not length bytes.
- DONE: done = 1, cpu_hold = 0, busy = 0.
- ERR: error = 1, cpu_hold = 1, busy = 0. Words already written are not rolled back.
- busy = 1 in LEN_HI, LEN_LO, DATA, CHK.
- Address arithmetic is 32-bit and wraps modulo 2^32. The word index is 16-bit.

## Timing
- Reset values (async, while rst = 0): state IDLE, in_ready 0, mem_we 0, mem_addr BASE_ADDR, mem_wdata 0, busy 0, done 0, error 0, cpu_hold 1.
- Reset asserted mid-load: immediate return to IDLE. The partial word is discarded and no mem_we is issued for it.
- Throughput: 1 byte/clk sustained, with no stall between words or around the mem_we cycle.
- Write latency: mem_we is high exactly one cycle, the cycle after the word's 4th byte is accepted. mem_addr/mem_wdata hold their values until the next write.
- busy rises the cycle after start is sampled.
- done/error and cpu_hold change the cycle after the checksum byte (or the bad LEN_LO byte) is accepted.
- in_valid gaps of any length are tolerated in every receiving state.

## Test plan
- Reset: drive rst = 0 mid-stream -> all outputs at reset values with no clock edge; cpu_hold = 1.
- Nominal: start, then bytes 00 02 20 08 00 05 20 09 00 0A 0E. Expect:
  - mem_we pulse at addr 0x0 with data 0x20080005, then at 0x4 with 0x2009000A;
  - done = 1 and cpu_hold = 0 one cycle after byte 0E.
- Checksum fail: same stream with final byte 0F -> both writes still occur; error = 1, done = 0, cpu_hold stays 1.
- Length bounds: count 00 00 -> ERR after LEN_LO. With MAX_WORDS = 256, count 01 01 -> ERR. In both cases no mem_we.
- Backpressure/gaps: insert random in_valid = 0 gaps into the nominal stream -> identical writes and result. Bytes offered in IDLE are not consumed.
- Restart: after DONE, pulse start and load count 1 with word 0xAABBCCDD, checksum 0x00 -> write 0xAABBCCDD at BASE_ADDR; cpu_hold is 1 during the load and 0 after.
